// File: rtl/ser_frame_rx.sv
// Framed serial receiver: start bit, DATA_W data bits LSB-first, optional even
// parity, stop bit. The good word is presented on q with a one-cycle q_valid strobe.
module ser_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              rx_d,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((BIT_CYCLES > 1) ? (BIT_CYCLES / 2 - 1) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DATA_W-1:0]  shift_r;
  logic               par_bad_r;
  logic               tick_s;

  // Nonzero when the data bits and the received parity bit have odd total weight.
  function automatic logic even_parity_err(input logic [DATA_W-1:0] data, input logic par_bit);
    return ^{data, par_bit};
  endfunction

  // New bit enters at the MSB; after DATA_W bits the first one received sits at bit0.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
    logic [DATA_W:0] ext;
    ext = {b, cur};
    return ext[DATA_W:1];
  endfunction

  // Mid-bit sample point: the bit-cycle counter has reached its last value.
  assign tick_s = (cnt_r == CNT_LAST);

  // Receive state machine with registered strobes and busy.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      shift_r    <= '0;
      par_bad_r  <= 1'b0;
      q          <= '0;
      q_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      q_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state_r)
        S_IDLE: begin
          cnt_r <= '0;
          if (!rx_d) begin
            busy <= 1'b1;
            if (BIT_CYCLES == 1) begin
              state_r   <= S_DATA;
              idx_r     <= '0;
              par_bad_r <= 1'b0;
            end else begin
              state_r <= S_START;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= '0;
            if (rx_d) begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              state_r   <= S_DATA;
              idx_r     <= '0;
              par_bad_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (tick_s) begin
            cnt_r   <= '0;
            shift_r <= shift_in(shift_r, rx_d);
            idx_r   <= idx_r + IDX_W'(1);
            if (idx_r == IDX_LAST) begin
              state_r <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              state_r <= S_DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (tick_s) begin
            cnt_r     <= '0;
            par_bad_r <= even_parity_err(shift_r, rx_d);
            state_r   <= S_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (tick_s) begin
            cnt_r <= '0;
            if (rx_d) begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
              if (par_bad_r && (PARITY_EN != 0)) begin
                parity_err <= 1'b1;
              end else begin
                q       <= shift_r;
                q_valid <= 1'b1;
              end
            end else begin
              // Line held low through the stop bit: wait for it to return high.
              state_r    <= S_WAIT_HI;
              frame_err  <= 1'b1;
              parity_err <= par_bad_r && (PARITY_EN != 0);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_WAIT_HI: begin
          cnt_r <= '0;
          if (rx_d) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= S_WAIT_HI;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_frame_rx.sv
// Bench for ser_frame_rx: four instances (1 and 4 clk/bit without parity,
// 1 and 3 clk/bit with even parity) driven by directed and random frames.
module tb_ser_frame_rx;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] rx;
  logic [7:0] q_a [4];
  logic [3:0] qv, fe, pe, bz;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ser_frame_rx #(
      .DATA_W    (8),
      .BIT_CYCLES((g == 1) ? 4 : ((g == 3) ? 3 : 1)),
      .PARITY_EN ((g >= 2) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset_p   (reset_p),
      .rx_d      (rx[g]),
      .q         (q_a[g]),
      .q_valid   (qv[g]),
      .frame_err (fe[g]),
      .parity_err(pe[g]),
      .busy      (bz[g])
    );
  end

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int nv[4], nf[4], np[4], lv[4], lf[4], lp[4];
  int wide = 0;
  logic [3:0] pqv = 4'b0, pfe = 4'b0, ppe = 4'b0;
  logic [7:0] exp_q [4];

  function automatic int bc_of(input int k);
    return (k == 1) ? 4 : ((k == 3) ? 3 : 1);
  endfunction

  function automatic int par_of(input int k);
    return (k >= 2) ? 1 : 0;
  endfunction

  // Strobe monitor: counts pulses and remembers the edge on which each appeared.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (qv[k] === 1'b1) begin nv[k] = nv[k] + 1; lv[k] = cyc; end
      if (fe[k] === 1'b1) begin nf[k] = nf[k] + 1; lf[k] = cyc; end
      if (pe[k] === 1'b1) begin np[k] = np[k] + 1; lp[k] = cyc; end
    end
    if (((qv & pqv) | (fe & pfe) | (pe & ppe)) === 4'b1111 ||
        ((qv & pqv) | (fe & pfe) | (pe & ppe)) != 4'b0000)
      wide = wide + 1;
    pqv = qv; pfe = fe; ppe = pe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks = nchecks + 1;
    assert (obs === exp) else begin
      nerrors = nerrors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k, input logic v);
    rx[k] = v;
    @(negedge clk);
  endtask

  // Drive one complete frame on instance k and check the outcome the frame rules predict.
  task automatic run_frame(input int k, input logic [7:0] data, input bit par_bad,
                           input bit stop_bit, input int hold);
    int bc, p, c, v0, f0, p0, ecyc;
    bit ev, ef, ep;
    logic pbit;
    bc = bc_of(k);
    p  = par_of(k);
    v0 = nv[k]; f0 = nf[k]; p0 = np[k];
    c  = cyc;
    repeat (bc) step(k, 1'b0);
    for (int i = 0; i < 8; i++) repeat (bc) step(k, data[i]);
    if (p != 0) begin
      pbit = (^data) ^ par_bad;
      repeat (bc) step(k, pbit);
    end
    repeat (bc) step(k, stop_bit);
    // Stop bit is sampled at mid-start + (8 data + parity + 1) bit periods.
    ecyc = c + 1 + bc / 2 + (9 + p) * bc;
    ev = stop_bit && !(p != 0 && par_bad);
    ef = !stop_bit;
    ep = (p != 0) && par_bad;
    if (ev) exp_q[k] = data;
    check($sformatf("u%0d q_valid count", k), nv[k] - v0, 32'(ev));
    check($sformatf("u%0d frame_err count", k), nf[k] - f0, 32'(ef));
    check($sformatf("u%0d parity_err count", k), np[k] - p0, 32'(ep));
    if (ev) check($sformatf("u%0d q_valid cycle", k), lv[k], ecyc);
    if (ef) check($sformatf("u%0d frame_err cycle", k), lf[k], ecyc);
    if (ep) check($sformatf("u%0d parity_err cycle", k), lp[k], ecyc);
    check($sformatf("u%0d q", k), 32'(q_a[k]), 32'(exp_q[k]));
    if (!stop_bit) begin
      repeat (hold) step(k, 1'b0);
      check($sformatf("u%0d busy in break", k), 32'(bz[k]), 32'd1);
      step(k, 1'b1);
      check($sformatf("u%0d busy after break", k), 32'(bz[k]), 32'd0);
      check($sformatf("u%0d no strobe in break", k), nv[k] - v0, 32'(ev));
    end else begin
      check($sformatf("u%0d busy after frame", k), 32'(bz[k]), 32'd0);
    end
  endtask

  initial begin
    int c1, v0, f0, p0, k, gap;
    logic [7:0] d, bits;
    bit sb, pb;

    reset_p = 1'b1;
    rx = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d reset q", i), 32'(q_a[i]), 32'd0);
      check($sformatf("u%0d reset strobes/busy", i), 32'({qv[i], fe[i], pe[i], bz[i]}), 32'd0);
    end
    @(negedge clk);

    // T1 and T2: single frame, then back-to-back frame with zero idle gap.
    run_frame(0, 8'hBC, 1'b0, 1'b1, 0);
    c1 = lv[0];
    run_frame(0, 8'h3A, 1'b0, 1'b1, 0);
    check("u0 back-to-back spacing", lv[0] - c1, 32'd10);

    // T3: bad stop bit, line held low.
    run_frame(0, 8'hBC, 1'b0, 1'b0, 5);

    // T4: start glitch at 4 clk/bit, then a real frame.
    v0 = nv[1]; f0 = nf[1];
    step(1, 1'b0);
    check("u1 glitch busy t0", 32'(bz[1]), 32'd1);
    step(1, 1'b1);
    check("u1 glitch busy before mid", 32'(bz[1]), 32'd1);
    step(1, 1'b1);
    check("u1 glitch busy after mid", 32'(bz[1]), 32'd0);
    repeat (4) step(1, 1'b1);
    check("u1 glitch no strobes", (nv[1] - v0) + (nf[1] - f0), 32'd0);
    run_frame(1, 8'h55, 1'b0, 1'b1, 0);

    // T5: parity error then the corrected frame.
    run_frame(2, 8'hBC, 1'b1, 1'b1, 0);
    run_frame(2, 8'hBC, 1'b0, 1'b1, 0);
    run_frame(3, 8'hC3, 1'b1, 1'b0, 2);

    // T6: reset mid-frame discards the partial word.
    v0 = nv[0]; f0 = nf[0]; p0 = np[0];
    bits = 8'hBC;
    step(0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, bits[i]);
    reset_p = 1'b1;
    step(0, bits[5]);
    reset_p = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q[i] = 8'h00;
      check($sformatf("u%0d midframe reset q", i), 32'(q_a[i]), 32'd0);
      check($sformatf("u%0d midframe reset outs", i), 32'({qv[i], fe[i], pe[i], bz[i]}), 32'd0);
    end
    repeat (3) step(0, 1'b1);
    check("u0 reset no strobes", (nv[0] - v0) + (nf[0] - f0) + (np[0] - p0), 32'd0);
    run_frame(0, 8'h3A, 1'b0, 1'b1, 0);

    // Random frames across all instances.
    repeat (40) begin
      k    = int'($urandom_range(0, 3));
      d    = 8'($urandom);
      sb   = ($urandom_range(0, 4) != 0);
      pb   = (par_of(k) != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      run_frame(k, d, pb, sb, int'($urandom_range(0, 3)));
      gap = int'($urandom_range(0, 2));
      repeat (gap) step(k, 1'b1);
    end

    check("strobe width", wide, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
